buyruk_bellek_modeli: RTL and testbench

- Parametrised, synthesizable instruction-memory responder for the core's fetch port (buyruk_istek_* / buyruk_yanit_*).
- Replaces ad-hoc counter-driven stimulus with a word-addressed memory that supports:
  - backdoor program loading;
  - configurable fixed response latency;
  - multiple outstanding in-order requests;
  - stall injection;
  - out-of-range/misaligned error flagging.
- Used in core-level benches and FPGA bring-up in place of the L1 instruction path.

---
 rtl/buyruk_bellek_modeli.sv | 139 +++++++++++++
 tb/tb_buyruk_bellek_modeli.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buyruk_bellek_modeli.sv
// Instruction-memory responder for the fetch port: word-addressed backdoor-loaded
// memory, fixed response latency, in-order outstanding request queue.
module buyruk_bellek_modeli #(
  parameter int                   ADRES_BIT       = 32,
  parameter int                   VERI_BIT        = 32,
  parameter int                   DERINLIK        = 1024,
  parameter logic [ADRES_BIT-1:0] BASLANGIC_ADRES = 'h4000_0000,
  parameter int                   GECIKME         = 2,
  parameter int                   KUYRUK          = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADRES_BIT-1:0] istek_adres_i,
  input  logic                 istek_gecerli_i,
  output logic                 istek_hazir_o,
  output logic [VERI_BIT-1:0]  yanit_veri_o,
  output logic                 yanit_hata_o,
  output logic                 yanit_gecerli_o,
  input  logic                 yanit_hazir_i,
  input  logic                 yukle_gecerli_i,
  input  logic [ADRES_BIT-1:0] yukle_adres_i,
  input  logic [VERI_BIT-1:0]  yukle_veri_i,
  input  logic                 durdur_i,
  output logic [31:0]          kabul_sayac_o,
  output logic [31:0]          yanit_sayac_o
);

  localparam int BAYT_BIT = $clog2(VERI_BIT / 8);
  localparam int IW       = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
  localparam int PW       = (KUYRUK > 1) ? $clog2(KUYRUK) : 1;
  localparam int SW       = $clog2(KUYRUK + 1);
  localparam int GW       = (GECIKME > 1) ? $clog2(GECIKME) : 1;

  localparam logic [ADRES_BIT-1:0] HIZA_MASKE = ADRES_BIT'((64'd1 << BAYT_BIT) - 64'd1);
  localparam logic [ADRES_BIT-1:0] DERINLIK_A = ADRES_BIT'(DERINLIK);
  localparam logic [GW-1:0]        GERI_YUKLE = GW'(GECIKME - 1);
  localparam logic [SW-1:0]        KUYRUK_S   = SW'(KUYRUK);
  localparam logic [PW-1:0]        SON_PTR    = PW'(KUYRUK - 1);

  // Offset wraps modulo 2^ADRES_BIT, so addresses below the base land out of range.
  function automatic logic adres_hata(input logic [ADRES_BIT-1:0] adres);
    logic [ADRES_BIT-1:0] ofs;
    ofs = adres - BASLANGIC_ADRES;
    return ((ofs & HIZA_MASKE) != '0) || ((ofs >> BAYT_BIT) >= DERINLIK_A);
  endfunction

  function automatic logic [IW-1:0] adres_indis(input logic [ADRES_BIT-1:0] adres);
    logic [ADRES_BIT-1:0] ofs;
    ofs = adres - BASLANGIC_ADRES;
    return IW'(ofs >> BAYT_BIT);
  endfunction

  function automatic logic [PW-1:0] sonraki(input logic [PW-1:0] ptr);
    return (ptr == SON_PTR) ? '0 : ptr + 1'b1;
  endfunction

  logic [VERI_BIT-1:0] bellek [DERINLIK];

  logic [VERI_BIT-1:0] k_veri    [KUYRUK];
  logic                k_hata    [KUYRUK];
  logic [GW-1:0]       k_geri    [KUYRUK];
  logic [KUYRUK-1:0]   k_gecerli;
  logic [PW-1:0]       yaz_ptr;
  logic [PW-1:0]       oku_ptr;
  logic [SW-1:0]       sayi;

  logic                istek_hata;
  logic [IW-1:0]       istek_indis;
  logic [VERI_BIT-1:0] okunan;
  logic                yukle_hata;
  logic [IW-1:0]       yukle_indis;
  logic                kabul;
  logic                cikar;
  logic                bas_hazir;

  always_comb begin
    istek_hata      = adres_hata(istek_adres_i);
    istek_indis     = adres_indis(istek_adres_i);
    yukle_hata      = adres_hata(yukle_adres_i);
    yukle_indis     = adres_indis(yukle_adres_i);
    okunan          = istek_hata ? '0 : bellek[istek_indis];
    istek_hazir_o   = !rst_i && !durdur_i && (sayi < KUYRUK_S);
    kabul           = istek_gecerli_i && istek_hazir_o;
    bas_hazir       = k_gecerli[oku_ptr] && (k_geri[oku_ptr] == '0);
    yanit_gecerli_o = bas_hazir;
    yanit_veri_o    = bas_hazir ? k_veri[oku_ptr] : '0;
    yanit_hata_o    = bas_hazir ? k_hata[oku_ptr] : 1'b0;
    cikar           = bas_hazir && yanit_hazir_i;
  end

  // Not reset, and writable during reset; same-edge fetch sees the pre-write word.
  always_ff @(posedge clk_i) begin
    if (yukle_gecerli_i && !yukle_hata) begin
      bellek[yukle_indis] <= yukle_veri_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < KUYRUK; i++) begin
        k_veri[i] <= '0;
        k_hata[i] <= 1'b0;
        k_geri[i] <= '0;
      end
      k_gecerli     <= '0;
      yaz_ptr       <= '0;
      oku_ptr       <= '0;
      sayi          <= '0;
      kabul_sayac_o <= '0;
      yanit_sayac_o <= '0;
    end else begin
      for (int i = 0; i < KUYRUK; i++) begin
        if (k_gecerli[i] && (k_geri[i] != '0)) begin
          k_geri[i] <= k_geri[i] - 1'b1;
        end
      end
      // The write slot is always free here, so it never collides with the popped head.
      if (kabul) begin
        k_veri[yaz_ptr]    <= okunan;
        k_hata[yaz_ptr]    <= istek_hata;
        k_geri[yaz_ptr]    <= GERI_YUKLE;
        k_gecerli[yaz_ptr] <= 1'b1;
        yaz_ptr            <= sonraki(yaz_ptr);
        kabul_sayac_o      <= kabul_sayac_o + 32'd1;
      end
      if (cikar) begin
        k_gecerli[oku_ptr] <= 1'b0;
        oku_ptr            <= sonraki(oku_ptr);
        yanit_sayac_o      <= yanit_sayac_o + 32'd1;
      end
      case ({kabul, cikar})
        2'b10:   sayi <= sayi + 1'b1;
        2'b01:   sayi <= sayi - 1'b1;
        default: sayi <= sayi;
      endcase
    end
  end

endmodule

// File: tb/tb_buyruk_bellek_modeli.sv
// Directed bench for buyruk_bellek_modeli with default parameters
// (GECIKME=2, KUYRUK=4, DERINLIK=1024, base 0x4000_0000).
module tb_buyruk_bellek_modeli;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] istek_adres_i = '0;
  logic        istek_gecerli_i = 1'b0;
  logic        istek_hazir_o;
  logic [31:0] yanit_veri_o;
  logic        yanit_hata_o;
  logic        yanit_gecerli_o;
  logic        yanit_hazir_i = 1'b0;
  logic        yukle_gecerli_i = 1'b0;
  logic [31:0] yukle_adres_i = '0;
  logic [31:0] yukle_veri_i = '0;
  logic        durdur_i = 1'b0;
  logic [31:0] kabul_sayac_o;
  logic [31:0] yanit_sayac_o;

  int checks = 0;
  int failures = 0;

  buyruk_bellek_modeli dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .istek_adres_i   (istek_adres_i),
    .istek_gecerli_i (istek_gecerli_i),
    .istek_hazir_o   (istek_hazir_o),
    .yanit_veri_o    (yanit_veri_o),
    .yanit_hata_o    (yanit_hata_o),
    .yanit_gecerli_o (yanit_gecerli_o),
    .yanit_hazir_i   (yanit_hazir_i),
    .yukle_gecerli_i (yukle_gecerli_i),
    .yukle_adres_i   (yukle_adres_i),
    .yukle_veri_i    (yukle_veri_i),
    .durdur_i        (durdur_i),
    .kabul_sayac_o   (kabul_sayac_o),
    .yanit_sayac_o   (yanit_sayac_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    istek_gecerli_i = 1'b0;
    yanit_hazir_i   = 1'b0;
    durdur_i        = 1'b0;
    rst_i           = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic load(input logic [31:0] adr, input logic [31:0] veri);
    yukle_gecerli_i = 1'b1;
    yukle_adres_i   = adr;
    yukle_veri_i    = veri;
    tick();
    yukle_gecerli_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    istek_gecerli_i = 1'b1;
    istek_adres_i = 32'h4000_0000;
    tick();
    tick();
    checks++;
    if (istek_hazir_o !== 1'b0) begin
      failures++; $display("FAIL reset_hazir got=%b exp=0", istek_hazir_o);
    end
    checks++;
    if ({yanit_gecerli_o, yanit_hata_o, yanit_veri_o} !== 34'd0) begin
      failures++; $display("FAIL reset_yanit got v=%b h=%b d=%h exp=0", yanit_gecerli_o, yanit_hata_o, yanit_veri_o);
    end
    checks++;
    if (kabul_sayac_o !== 32'd0 || yanit_sayac_o !== 32'd0) begin
      failures++; $display("FAIL reset_sayac got kabul=%0d yanit=%0d exp=0", kabul_sayac_o, yanit_sayac_o);
    end
    istek_gecerli_i = 1'b0;
  endtask

  task automatic test_load_fetch();
    do_reset();
    for (int i = 0; i < 6; i++) load(32'h4000_0000 + 32'(4 * i), 32'h0010_8093);
    yanit_hazir_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      istek_gecerli_i = (c < 6);
      istek_adres_i   = 32'h4000_0000 + 32'(4 * c);
      #1;
      if (c < 6) begin
        checks++;
        if (istek_hazir_o !== 1'b1) begin
          failures++; $display("FAIL lf_hazir c=%0d got=%b exp=1", c, istek_hazir_o);
        end
      end
      checks++;
      if (yanit_gecerli_o !== (c >= 2 && c <= 7)) begin
        failures++; $display("FAIL lf_gecerli c=%0d got=%b exp=%b", c, yanit_gecerli_o, (c >= 2 && c <= 7));
      end
      if (c >= 2 && c <= 7) begin
        checks++;
        if (yanit_veri_o !== 32'h0010_8093 || yanit_hata_o !== 1'b0) begin
          failures++; $display("FAIL lf_veri c=%0d got=%h h=%b exp=00108093 h=0", c, yanit_veri_o, yanit_hata_o);
        end
      end
      tick();
    end
    checks++;
    if (kabul_sayac_o !== 32'd6 || yanit_sayac_o !== 32'd6) begin
      failures++; $display("FAIL lf_sayac got kabul=%0d yanit=%0d exp=6/6", kabul_sayac_o, yanit_sayac_o);
    end
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    istek_gecerli_i = 1'b1;
    istek_adres_i   = 32'h4000_0000;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (istek_hazir_o !== (c < 4)) begin
        failures++; $display("FAIL lim_hazir c=%0d got=%b exp=%b", c, istek_hazir_o, (c < 4));
      end
      tick();
    end
    checks++;
    if (kabul_sayac_o !== 32'd4) begin
      failures++; $display("FAIL lim_kabul got=%0d exp=4", kabul_sayac_o);
    end
    yanit_hazir_i = 1'b1;
    #1;
    checks++;
    if (yanit_gecerli_o !== 1'b1 || istek_hazir_o !== 1'b0) begin
      failures++; $display("FAIL lim_pop_cycle got v=%b hazir=%b exp v=1 hazir=0", yanit_gecerli_o, istek_hazir_o);
    end
    tick();
    yanit_hazir_i = 1'b0;
    #1;
    checks++;
    if (istek_hazir_o !== 1'b1) begin
      failures++; $display("FAIL lim_after_pop got=%b exp=1", istek_hazir_o);
    end
    tick();
    istek_gecerli_i = 1'b0;
    #1;
    checks++;
    if (kabul_sayac_o !== 32'd5 || yanit_sayac_o !== 32'd1 || istek_hazir_o !== 1'b0) begin
      failures++; $display("FAIL lim_refill got kabul=%0d yanit=%0d hazir=%b exp 5/1/0", kabul_sayac_o, yanit_sayac_o, istek_hazir_o);
    end
  endtask

  task automatic test_errors();
    logic [31:0] adr [4];
    logic [31:0] exp_d [4];
    logic        exp_h [4];
    adr[0] = 32'h4000_0002; exp_d[0] = 32'h0; exp_h[0] = 1'b1;
    adr[1] = 32'h4000_1000; exp_d[1] = 32'h0; exp_h[1] = 1'b1;
    adr[2] = 32'h4000_0000; exp_d[2] = 32'h0010_8093; exp_h[2] = 1'b0;
    adr[3] = 32'h3FFF_FFFC; exp_d[3] = 32'h0; exp_h[3] = 1'b1;
    do_reset();
    yanit_hazir_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      istek_gecerli_i = (c < 4);
      istek_adres_i   = (c < 4) ? adr[c] : 32'h0;
      #1;
      if (c >= 2 && c <= 5) begin
        checks++;
        if (yanit_gecerli_o !== 1'b1 || yanit_veri_o !== exp_d[c-2] || yanit_hata_o !== exp_h[c-2]) begin
          failures++; $display("FAIL err_yanit c=%0d got v=%b d=%h h=%b exp v=1 d=%h h=%b",
                               c, yanit_gecerli_o, yanit_veri_o, yanit_hata_o, exp_d[c-2], exp_h[c-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d;
    do_reset();
    load(32'h4000_0000, 32'h1111_1111);
    load(32'h4000_0004, 32'h2222_2222);
    load(32'h4000_0008, 32'h3333_3333);
    for (int c = 0; c < 11; c++) begin
      istek_gecerli_i = (c < 3);
      istek_adres_i   = 32'h4000_0000 + 32'(4 * c);
      yanit_hazir_i   = (c >= 7);
      #1;
      exp_d = (c >= 2 && c <= 7) ? 32'h1111_1111 :
              (c == 8) ? 32'h2222_2222 : (c == 9) ? 32'h3333_3333 : 32'h0;
      checks++;
      if (yanit_gecerli_o !== (c >= 2 && c <= 9) || yanit_veri_o !== exp_d || yanit_hata_o !== 1'b0) begin
        failures++; $display("FAIL bp c=%0d got v=%b d=%h h=%b exp v=%b d=%h h=0",
                             c, yanit_gecerli_o, yanit_veri_o, yanit_hata_o, (c >= 2 && c <= 9), exp_d);
      end
      tick();
    end
  endtask

  task automatic test_stall_same_cycle_load();
    logic [31:0] exp_d;
    logic        exp_v;
    do_reset();
    yanit_hazir_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      durdur_i        = (c >= 2 && c <= 4);
      istek_gecerli_i = (c <= 6);
      istek_adres_i   = (c <= 4) ? 32'h4000_0004 : 32'h4000_0000;
      yukle_gecerli_i = (c == 5);
      yukle_adres_i   = 32'h4000_0000;
      yukle_veri_i    = 32'hDEAD_BEEF;
      #1;
      if (c <= 6) begin
        checks++;
        if (istek_hazir_o !== !(c >= 2 && c <= 4)) begin
          failures++; $display("FAIL stall_hazir c=%0d got=%b exp=%b", c, istek_hazir_o, !(c >= 2 && c <= 4));
        end
      end
      exp_v = (c == 2 || c == 3 || c == 7 || c == 8);
      exp_d = (c == 2 || c == 3) ? 32'h2222_2222 : (c == 7) ? 32'h1111_1111 :
              (c == 8) ? 32'hDEAD_BEEF : 32'h0;
      checks++;
      if (yanit_gecerli_o !== exp_v || yanit_veri_o !== exp_d) begin
        failures++; $display("FAIL stall_yanit c=%0d got v=%b d=%h exp v=%b d=%h", c, yanit_gecerli_o, yanit_veri_o, exp_v, exp_d);
      end
      tick();
    end
    durdur_i = 1'b0;
    yukle_gecerli_i = 1'b0;
    checks++;
    if (kabul_sayac_o !== 32'd4 || yanit_sayac_o !== 32'd4) begin
      failures++; $display("FAIL stall_sayac got kabul=%0d yanit=%0d exp=4/4", kabul_sayac_o, yanit_sayac_o);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    istek_gecerli_i = 1'b1;
    istek_adres_i   = 32'h4000_0008;
    tick(); tick(); tick();
    istek_gecerli_i = 1'b0;
    tick();
    checks++;
    if (yanit_gecerli_o !== 1'b1 || kabul_sayac_o !== 32'd3) begin
      failures++; $display("FAIL mr_pre got v=%b kabul=%0d exp v=1 kabul=3", yanit_gecerli_o, kabul_sayac_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (yanit_gecerli_o !== 1'b0 || yanit_veri_o !== 32'h0 || kabul_sayac_o !== 32'd0 ||
        yanit_sayac_o !== 32'd0 || istek_hazir_o !== 1'b0) begin
      failures++; $display("FAIL mr_async got v=%b d=%h kabul=%0d yanit=%0d hazir=%b exp all 0",
                           yanit_gecerli_o, yanit_veri_o, kabul_sayac_o, yanit_sayac_o, istek_hazir_o);
    end
    tick();
    rst_i = 1'b0;
    yanit_hazir_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (yanit_gecerli_o !== 1'b0 || istek_hazir_o !== 1'b1) begin
        failures++; $display("FAIL mr_stale c=%0d got v=%b hazir=%b exp v=0 hazir=1", c, yanit_gecerli_o, istek_hazir_o);
      end
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      istek_gecerli_i = (c < 2);
      istek_adres_i   = (c == 0) ? 32'h4000_0008 : 32'h4000_0000;
      #1;
      if (c == 2 || c == 3) begin
        checks++;
        if (yanit_gecerli_o !== 1'b1 || yanit_veri_o !== ((c == 2) ? 32'h3333_3333 : 32'hDEAD_BEEF)) begin
          failures++; $display("FAIL mr_retain c=%0d got v=%b d=%h exp v=1 d=%h", c, yanit_gecerli_o, yanit_veri_o,
                               (c == 2) ? 32'h3333_3333 : 32'hDEAD_BEEF);
        end
      end
      tick();
    end
    checks++;
    if (kabul_sayac_o !== 32'd2 || yanit_sayac_o !== 32'd2) begin
      failures++; $display("FAIL mr_sayac got kabul=%0d yanit=%0d exp=2/2", kabul_sayac_o, yanit_sayac_o);
    end
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_outstanding_limit();
    test_errors();
    test_backpressure();
    test_stall_same_cycle_load();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
